// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: one outstanding memory read at a time, feeding a small response FIFO.
// Optional macro FETCH_MISALIGN_CHECK_EN turns misaligned PCs into faulting NOP entries.
module instr_fetch_unit #(
    parameter int FIFO_DEPTH = 2,
    parameter int XLEN       = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_i,
    input  logic            pc_valid_i,
    output logic            pc_ready_o,
    input  logic            flush_i,
    output logic            mem_req_o,
    output logic [XLEN-1:0] mem_addr_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rdata_i,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] instr_pc_o,
    output logic            instr_valid_o,
    input  logic            instr_ready_i,
    output logic            misalign_o
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DISCARD
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            flush_held;
    logic            flush_held_nxt;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] pc_q;

    logic [XLEN-1:0] fifo_instr [FIFO_DEPTH];
    logic [XLEN-1:0] fifo_pc    [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    logic            fifo_empty;
    logic            fifo_full;
    logic            handshake;
    logic            misaligned;
    logic            push_fetch;
    logic            push_nop;
    logic            push;
    logic            pop;
    logic [XLEN-1:0] push_instr;
    logic [XLEN-1:0] push_pc;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(FIFO_DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));

    // A slot is reserved at handshake time, so a full FIFO blocks new fetches.
    assign pc_ready_o = (state == IDLE) && !flush_i && !fifo_full;
    assign handshake  = pc_valid_i && pc_ready_o;

    assign mem_req_o     = (state == REQ);
    assign mem_addr_o    = addr_q;
    assign instr_valid_o = !fifo_empty;
    assign pop           = instr_valid_o && instr_ready_i;
    assign instr_o       = instr_valid_o ? fifo_instr[rd_ptr] : '0;
    assign instr_pc_o    = instr_valid_o ? fifo_pc[rd_ptr] : '0;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign misaligned = (pc_i[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign push_nop   = handshake && misaligned;
    assign push       = push_fetch || push_nop;
    assign push_instr = push_fetch ? mem_rdata_i : XLEN'(32'h0000_0013);
    assign push_pc    = push_fetch ? pc_q : pc_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            flush_held <= 1'b0;
            addr_q     <= '0;
            pc_q       <= '0;
        end else begin
            state      <= state_nxt;
            flush_held <= flush_held_nxt;
            if (handshake && !misaligned) begin
                addr_q <= {pc_i[XLEN-1:2], 2'b00};
                pc_q   <= pc_i;
            end
        end
    end

    // A request already on the bus is never retracted; a flush seen before the
    // grant is remembered so the eventual response is dropped.
    always_comb begin
        state_nxt      = state;
        flush_held_nxt = flush_held;
        push_fetch     = 1'b0;
        case (state)
            IDLE: begin
                flush_held_nxt = 1'b0;
                if (handshake && !misaligned) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (mem_gnt_i) begin
                    state_nxt      = (flush_i || flush_held) ? DISCARD : WAIT;
                    flush_held_nxt = 1'b0;
                end else if (flush_i) begin
                    flush_held_nxt = 1'b1;
                end
            end
            WAIT: begin
                if (mem_rvalid_i) begin
                    state_nxt  = IDLE;
                    push_fetch = !flush_i;
                end else if (flush_i) begin
                    state_nxt = DISCARD;
                end
            end
            DISCARD: begin
                if (mem_rvalid_i) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_instr[i] <= '0;
                fifo_pc[i]    <= '0;
            end
        end else if (flush_i) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) begin
                fifo_instr[wr_ptr] <= push_instr;
                fifo_pc[wr_ptr]    <= push_pc;
                wr_ptr             <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    logic fifo_mis [FIFO_DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mis[i] <= 1'b0;
            end
        end else if (push && !flush_i) begin
            fifo_mis[wr_ptr] <= push_nop;
        end
    end

    assign misalign_o = instr_valid_o && fifo_mis[rd_ptr];
`else
    assign misalign_o = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed vector table, corner-case
// sequences, and randomized traffic against a transaction-level queue model.
module tb_instr_fetch_unit;

    localparam int DEPTH = 2;

    logic        clk;
    logic        rst;
    logic [31:0] pc_i;
    logic        pc_valid_i;
    logic        pc_ready_o;
    logic        flush_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic        misalign_o;

    int checks;
    int errors;

    typedef struct {
        logic        pc_valid;
        logic [31:0] pc;
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        flush;
        logic        ready;
        logic        exp_pc_ready;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_instr;
        logic [31:0] exp_pc;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        mis;
    } entry_t;

    vec_t   vecs[11];
    entry_t mq[$];

    logic        m_busy;
    logic        m_granted;
    logic        m_doomed;
    logic [31:0] m_pc;

    instr_fetch_unit #(
        .FIFO_DEPTH(DEPTH),
        .XLEN      (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_i         (pc_i),
        .pc_valid_i   (pc_valid_i),
        .pc_ready_o   (pc_ready_o),
        .flush_i      (flush_i),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .instr_o      (instr_o),
        .instr_pc_o   (instr_pc_o),
        .instr_valid_o(instr_valid_o),
        .instr_ready_i(instr_ready_i),
        .misalign_o   (misalign_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic pv, input logic [31:0] pc, input logic gnt,
                                input logic rv, input logic [31:0] rdata, input logic flush,
                                input logic rdy, input logic e_prdy, input logic e_req,
                                input logic [31:0] e_addr, input logic e_valid,
                                input logic [31:0] e_instr, input logic [31:0] e_pc);
        vec_t v;
        v.pc_valid = pv;      v.pc = pc;           v.gnt = gnt;
        v.rvalid = rv;        v.rdata = rdata;     v.flush = flush;
        v.ready = rdy;        v.exp_pc_ready = e_prdy;
        v.exp_req = e_req;    v.exp_addr = e_addr; v.exp_valid = e_valid;
        v.exp_instr = e_instr; v.exp_pc = e_pc;
        return v;
    endfunction

    function automatic vec_t stim(input logic pv, input logic [31:0] pc, input logic gnt,
                                  input logic rv, input logic [31:0] rdata, input logic flush,
                                  input logic rdy);
        return mk(pv, pc, gnt, rv, rdata, flush, rdy, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    endfunction

    task automatic applyStimulus(input vec_t v);
        pc_valid_i    = v.pc_valid;
        pc_i          = v.pc;
        mem_gnt_i     = v.gnt;
        mem_rvalid_i  = v.rvalid;
        mem_rdata_i   = v.rdata;
        flush_i       = v.flush;
        instr_ready_i = v.ready;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    // Drive one cycle's inputs at the falling edge and let outputs settle.
    task automatic driveCycle(input vec_t v);
        @(negedge clk);
        applyStimulus(v);
        #1;
    endtask

    task automatic checkVector(input int i);
        checkOutput($sformatf("vec%0d_pc_ready", i), 32'(pc_ready_o), 32'(vecs[i].exp_pc_ready));
        checkOutput($sformatf("vec%0d_mem_req", i), 32'(mem_req_o), 32'(vecs[i].exp_req));
        if (vecs[i].exp_req) begin
            checkOutput($sformatf("vec%0d_mem_addr", i), mem_addr_o, vecs[i].exp_addr);
        end
        checkOutput($sformatf("vec%0d_valid", i), 32'(instr_valid_o), 32'(vecs[i].exp_valid));
        if (vecs[i].exp_valid) begin
            checkOutput($sformatf("vec%0d_instr", i), instr_o, vecs[i].exp_instr);
            checkOutput($sformatf("vec%0d_instr_pc", i), instr_pc_o, vecs[i].exp_pc);
        end
    endtask

    task automatic runRandom(input int cycles);
        vec_t        v;
        logic        exp_ready;
        logic        do_pop;
        logic        have_push;
        logic        mis;
        entry_t      pe;
        logic [31:0] pc;
        for (int n = 0; n < cycles; n++) begin
            pc = $urandom;
            if ($urandom_range(3) != 0) pc[1:0] = 2'b00;
            v = stim(1'($urandom_range(1)), pc, ($urandom_range(2) != 0),
                     ($urandom_range(2) == 0), $urandom, ($urandom_range(15) == 0),
                     ($urandom_range(2) != 0));
            driveCycle(v);

            exp_ready = !m_busy && !v.flush && (mq.size() < DEPTH);
            checkOutput("rnd_pc_ready", 32'(pc_ready_o), 32'(exp_ready));
            checkOutput("rnd_mem_req", 32'(mem_req_o), 32'(m_busy && !m_granted));
            if (m_busy && !m_granted) begin
                checkOutput("rnd_mem_addr", mem_addr_o, {m_pc[31:2], 2'b00});
            end
            checkOutput("rnd_valid", 32'(instr_valid_o), 32'(mq.size() != 0));
            if (mq.size() != 0) begin
                checkOutput("rnd_instr", instr_o, mq[0].instr);
                checkOutput("rnd_instr_pc", instr_pc_o, mq[0].pc);
                checkOutput("rnd_misalign", 32'(misalign_o), 32'(mq[0].mis));
            end

            do_pop    = (mq.size() != 0) && v.ready;
            have_push = 1'b0;
            pe        = '{32'h0, 32'h0, 1'b0};
            if (m_busy && m_granted && v.rvalid) begin
                if (!m_doomed && !v.flush) begin
                    have_push = 1'b1;
                    pe        = '{v.rdata, m_pc, 1'b0};
                end
                m_busy = 1'b0;
            end else if (m_busy) begin
                if (!m_granted && v.gnt) m_granted = 1'b1;
                if (v.flush) m_doomed = 1'b1;
            end
`ifdef FETCH_MISALIGN_CHECK_EN
            mis = (v.pc[1:0] != 2'b00);
`else
            mis = 1'b0;
`endif
            if (exp_ready && v.pc_valid) begin
                if (mis) begin
                    have_push = 1'b1;
                    pe        = '{32'h0000_0013, v.pc, 1'b1};
                end else begin
                    m_busy    = 1'b1;
                    m_granted = 1'b0;
                    m_doomed  = 1'b0;
                    m_pc      = v.pc;
                end
            end
            if (v.flush) begin
                mq.delete();
            end else begin
                if (do_pop) void'(mq.pop_front());
                if (have_push) mq.push_back(pe);
            end
        end
    endtask

    initial begin
        vec_t zero_v;
        checks = 0;
        errors = 0;
        zero_v = stim(0, 32'h0, 0, 0, 32'h0, 0, 0);
        rst = 1'b0;
        applyStimulus(zero_v);

        vecs[0]  = mk(1, 32'h100, 0, 0, 32'h0,        0, 0, 1, 0, 32'h0,   0, 32'h0,        32'h0);
        vecs[1]  = mk(0, 32'h0,   1, 0, 32'h0,        0, 0, 0, 1, 32'h100, 0, 32'h0,        32'h0);
        vecs[2]  = mk(0, 32'h0,   0, 1, 32'h00500093, 0, 0, 0, 0, 32'h0,   0, 32'h0,        32'h0);
        vecs[3]  = mk(1, 32'h0,   0, 0, 32'h0,        0, 0, 1, 0, 32'h0,   1, 32'h00500093, 32'h100);
        vecs[4]  = mk(0, 32'h0,   1, 0, 32'h0,        0, 0, 0, 1, 32'h0,   1, 32'h00500093, 32'h100);
        vecs[5]  = mk(0, 32'h0,   0, 1, 32'h11111111, 0, 0, 0, 0, 32'h0,   1, 32'h00500093, 32'h100);
        vecs[6]  = mk(0, 32'h0,   0, 0, 32'h0,        0, 0, 0, 0, 32'h0,   1, 32'h00500093, 32'h100);
        vecs[7]  = mk(0, 32'h0,   0, 0, 32'h0,        0, 1, 0, 0, 32'h0,   1, 32'h00500093, 32'h100);
        vecs[8]  = mk(0, 32'h0,   0, 0, 32'h0,        0, 0, 1, 0, 32'h0,   1, 32'h11111111, 32'h0);
        vecs[9]  = mk(0, 32'h0,   0, 0, 32'h0,        1, 0, 0, 0, 32'h0,   1, 32'h11111111, 32'h0);
        vecs[10] = mk(0, 32'h0,   0, 0, 32'h0,        0, 0, 1, 0, 32'h0,   0, 32'h0,        32'h0);

        #12;
        checkOutput("reset_mem_req", 32'(mem_req_o), 32'h0);
        checkOutput("reset_mem_addr", mem_addr_o, 32'h0);
        checkOutput("reset_valid", 32'(instr_valid_o), 32'h0);
        checkOutput("reset_instr", instr_o, 32'h0);
        checkOutput("reset_instr_pc", instr_pc_o, 32'h0);
        checkOutput("reset_misalign", 32'(misalign_o), 32'h0);
        @(negedge clk);
        rst = 1'b1;

        $display("[TB] directed vector table");
        for (int i = 0; i < 11; i++) begin
            driveCycle(vecs[i]);
            checkVector(i);
        end

        $display("[TB] grant withheld for five cycles");
        driveCycle(stim(1, 32'h2000, 0, 0, 32'h0, 0, 0));
        checkOutput("stall_pc_ready", 32'(pc_ready_o), 32'h1);
        for (int i = 0; i < 5; i++) begin
            driveCycle(zero_v);
            checkOutput($sformatf("stall%0d_mem_req", i), 32'(mem_req_o), 32'h1);
            checkOutput($sformatf("stall%0d_mem_addr", i), mem_addr_o, 32'h2000);
        end
        driveCycle(stim(0, 32'h0, 1, 0, 32'h0, 0, 0));
        driveCycle(stim(0, 32'h0, 0, 1, 32'hCAFE0001, 0, 0));
        checkOutput("stall_req_after_gnt", 32'(mem_req_o), 32'h0);
        driveCycle(stim(0, 32'h0, 0, 0, 32'h0, 0, 1));
        checkOutput("stall_valid", 32'(instr_valid_o), 32'h1);
        checkOutput("stall_instr", instr_o, 32'hCAFE0001);
        checkOutput("stall_instr_pc", instr_pc_o, 32'h2000);
        driveCycle(zero_v);
        checkOutput("stall_popped", 32'(instr_valid_o), 32'h0);

        $display("[TB] flush while request is pending");
        driveCycle(stim(1, 32'h3000, 0, 0, 32'h0, 0, 0));
        driveCycle(stim(0, 32'h0, 0, 0, 32'h0, 1, 0));
        checkOutput("flreq_req_held", 32'(mem_req_o), 32'h1);
        checkOutput("flreq_addr_held", mem_addr_o, 32'h3000);
        driveCycle(stim(0, 32'h0, 1, 0, 32'h0, 0, 0));
        checkOutput("flreq_req_until_gnt", 32'(mem_req_o), 32'h1);
        driveCycle(zero_v);
        checkOutput("flreq_discard_req", 32'(mem_req_o), 32'h0);
        checkOutput("flreq_discard_busy", 32'(pc_ready_o), 32'h0);
        driveCycle(stim(0, 32'h0, 0, 1, 32'h12345678, 0, 0));
        driveCycle(zero_v);
        checkOutput("flreq_dropped", 32'(instr_valid_o), 32'h0);
        checkOutput("flreq_idle", 32'(pc_ready_o), 32'h1);

        $display("[TB] flush during wait then late response");
        driveCycle(stim(1, 32'h4000, 0, 0, 32'h0, 0, 0));
        driveCycle(stim(0, 32'h0, 1, 0, 32'h0, 0, 0));
        driveCycle(stim(0, 32'h0, 0, 0, 32'h0, 1, 0));
        driveCycle(stim(0, 32'h0, 0, 1, 32'hDEADBEEF, 0, 0));
        checkOutput("flwait_discard_busy", 32'(pc_ready_o), 32'h0);
        driveCycle(zero_v);
        checkOutput("flwait_dropped", 32'(instr_valid_o), 32'h0);
        checkOutput("flwait_idle", 32'(pc_ready_o), 32'h1);

        $display("[TB] flush together with response");
        driveCycle(stim(1, 32'h5000, 0, 0, 32'h0, 0, 0));
        driveCycle(stim(0, 32'h0, 1, 0, 32'h0, 0, 0));
        driveCycle(stim(0, 32'h0, 0, 1, 32'h0BAD0BAD, 1, 0));
        driveCycle(zero_v);
        checkOutput("flrv_dropped", 32'(instr_valid_o), 32'h0);
        checkOutput("flrv_idle", 32'(pc_ready_o), 32'h1);

        $display("[TB] reset in the middle of a request");
        driveCycle(stim(1, 32'h6000, 0, 0, 32'h0, 0, 0));
        driveCycle(stim(0, 32'h0, 1, 0, 32'h0, 0, 0));
        driveCycle(stim(0, 32'h0, 0, 1, 32'h0000600D, 0, 0));
        driveCycle(stim(1, 32'h7000, 0, 0, 32'h0, 0, 0));
        checkOutput("rstreq_pc_ready", 32'(pc_ready_o), 32'h1);
        driveCycle(zero_v);
        checkOutput("rstreq_req_before", 32'(mem_req_o), 32'h1);
        checkOutput("rstreq_valid_before", 32'(instr_valid_o), 32'h1);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("rstreq_req_async", 32'(mem_req_o), 32'h0);
        checkOutput("rstreq_valid_async", 32'(instr_valid_o), 32'h0);
        checkOutput("rstreq_addr_async", mem_addr_o, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("rstreq_idle", 32'(pc_ready_o), 32'h1);
        driveCycle(stim(0, 32'h0, 0, 1, 32'h0BADF00D, 0, 0));
        driveCycle(zero_v);
        checkOutput("rstreq_stray_rvalid", 32'(instr_valid_o), 32'h0);

        $display("[TB] misaligned pc");
        driveCycle(stim(1, 32'h102, 0, 0, 32'h0, 0, 0));
        checkOutput("mis_pc_ready", 32'(pc_ready_o), 32'h1);
        driveCycle(zero_v);
`ifdef FETCH_MISALIGN_CHECK_EN
        checkOutput("mis_no_req", 32'(mem_req_o), 32'h0);
        checkOutput("mis_valid", 32'(instr_valid_o), 32'h1);
        checkOutput("mis_instr", instr_o, 32'h0000_0013);
        checkOutput("mis_instr_pc", instr_pc_o, 32'h102);
        checkOutput("mis_flag", 32'(misalign_o), 32'h1);
        driveCycle(stim(0, 32'h0, 0, 0, 32'h0, 0, 1));
`else
        checkOutput("mis_req", 32'(mem_req_o), 32'h1);
        checkOutput("mis_addr", mem_addr_o, 32'h100);
        driveCycle(stim(0, 32'h0, 1, 0, 32'h0, 0, 0));
        driveCycle(stim(0, 32'h0, 0, 1, 32'h00A00113, 0, 0));
        driveCycle(zero_v);
        checkOutput("mis_valid", 32'(instr_valid_o), 32'h1);
        checkOutput("mis_instr_pc", instr_pc_o, 32'h102);
        checkOutput("mis_flag", 32'(misalign_o), 32'h0);
        driveCycle(stim(0, 32'h0, 0, 0, 32'h0, 0, 1));
`endif
        driveCycle(zero_v);
        checkOutput("mis_popped", 32'(instr_valid_o), 32'h0);

        $display("[TB] randomized traffic against queue model");
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(zero_v);
        @(negedge clk);
        rst       = 1'b1;
        m_busy    = 1'b0;
        m_granted = 1'b0;
        m_doomed  = 1'b0;
        m_pc      = 32'h0;
        mq.delete();
        runRandom(2000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter FIFO_DEPTH, default 2: response buffer entries; legal values 2 to 8.
REQ-002 Parameter XLEN, default 32: address and instruction width.
REQ-003 clk  input  1: single clock; all state updates on the rising edge.
REQ-004 rst  input  1: reset, asynchronous assert, active-low.
REQ-005 pc_i  input  XLEN: fetch address from the PC register.
REQ-006 pc_valid_i  input  1: pc_i holds a fetch request.
REQ-007 pc_ready_o  output  1: unit accepts pc_i this cycle.
REQ-008 flush_i  input  1: discard all pending and buffered fetches.
REQ-009 mem_req_o  output  1: memory read request.
REQ-010 mem_addr_o  output  XLEN: word-aligned memory address.
REQ-011 mem_gnt_i  input  1: memory accepted the request.
REQ-012 mem_rvalid_i  input  1: mem_rdata_i valid.
REQ-013 mem_rdata_i  input  XLEN: fetched instruction word.
REQ-014 instr_o  output  XLEN: instruction at the FIFO head.
REQ-015 instr_pc_o  output  XLEN: PC of instr_o.
REQ-016 instr_valid_o  output  1: FIFO head valid.
REQ-017 instr_ready_i  input  1: decode consumes the head.
REQ-018 misalign_o  output  1: head entry carries a misaligned-PC fault.

Function
REQ-019 The FSM SHALL have states IDLE, REQ, WAIT and DISCARD, with at most one memory request outstanding.
REQ-020 pc_ready_o SHALL be 1 only when state=IDLE, flush_i=0, and FIFO count < FIFO_DEPTH.
REQ-021 A handshake (pc_valid_i & pc_ready_o) SHALL register mem_addr_o={pc_i[XLEN-1:2],2'b00}, latch the PC, and enter REQ with mem_req_o=1 the next cycle.
REQ-022 In REQ, mem_req_o and mem_addr_o SHALL hold stable until mem_gnt_i=1, then go to WAIT with mem_req_o=0 the following cycle.
REQ-023 In WAIT, mem_rvalid_i=1 SHALL push {mem_rdata_i, latched PC, misalign=0} into the FIFO and return to IDLE.
REQ-024 A pushed entry SHALL appear on instr_valid_o the cycle after the push; fetch latency is pc handshake to instr_valid_o of 3 cycles plus grant and rvalid wait cycles.
REQ-025 The FIFO SHALL pop on instr_valid_o & instr_ready_i; a push and pop in the same cycle SHALL leave the count unchanged.
REQ-026 The FIFO SHALL never overflow, because REQ-020 reserves the slot; a pop from an empty FIFO SHALL be ignored.
REQ-027 When flush_i=1, the FIFO SHALL be emptied in the next cycle, and any push in that cycle SHALL be dropped.
REQ-028 Flush in IDLE SHALL leave the state at IDLE.
REQ-029 Flush in REQ SHALL keep the request held until grant and then enter DISCARD; a request is never retracted.
REQ-030 Flush in WAIT SHALL enter DISCARD; a flush with a simultaneous rvalid SHALL enter IDLE and drop the data.
REQ-031 In DISCARD, mem_rvalid_i=1 SHALL drop the data and return to IDLE.
REQ-032 mem_rvalid_i outside WAIT and DISCARD SHALL be ignored.

Reset
REQ-033 rst=0 SHALL immediately force state=IDLE, FIFO empty, mem_req_o=0, mem_addr_o=0, instr_valid_o=0, instr_o=0, instr_pc_o=0 and misalign_o=0.
REQ-034 A reset mid-transaction SHALL abandon the outstanding request without a discard phase.

Configuration
REQ-035 With macro FETCH_MISALIGN_CHECK_EN defined, an accepted pc_i with pc_i[1:0]!=0 SHALL issue no memory request and SHALL push {32'h00000013, pc_i, misalign=1} the next cycle, staying in IDLE.
REQ-036 Without FETCH_MISALIGN_CHECK_EN, pc_i[1:0] SHALL be ignored and misalign_o SHALL be tied to 0.

Verification
REQ-037 Reset then pc_i=0x100 with gnt same cycle and rvalid next cycle, rdata=0x00500093 -> instr_o=0x00500093, instr_pc_o=0x100 and instr_valid_o=1.
REQ-038 Hold instr_ready_i=0 and fetch 0x0, 0x4 (FIFO_DEPTH=2) -> pc_ready_o=0 after the second push; one pop -> pc_ready_o=1 the next cycle.
REQ-039 Withhold mem_gnt_i for 5 cycles -> mem_req_o=1 and mem_addr_o constant all 5 cycles.
REQ-040 flush_i in WAIT, then rvalid with rdata=0xDEADBEEF -> no instr_valid_o, state returns to IDLE and pc_ready_o=1.
REQ-041 rst=0 asserted mid-REQ -> mem_req_o=0 before the next clock edge, and instr_valid_o=0.
REQ-042 With FETCH_MISALIGN_CHECK_EN defined, pc_i=0x102 -> mem_req_o stays 0, instr_o=0x00000013 and misalign_o=1.
